// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_pkg
//  Description : Shared AXI4-Lite response codes and the command master's
//                FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package axi_lite_pkg;

  // AXI4-Lite BRESP/RRESP encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Sequencer states; one transaction in flight at a time
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/axi_lite_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_cmd_master
//  Description : Single-outstanding AXI4-Lite master. Accepts a cmd/rsp
//                request and runs one AXI4-Lite write or read for it. All
//                outputs are registered. AWPROT/ARPROT (3'b000) and WSTRB
//                (all ones) are constant and tied off where this block is
//                integrated, so they are not ports here.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          areset,
  // command / response port
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                          rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                    rsp_resp,
  // write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  // write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  // write response channel
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  // read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  // read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  state_e                          state_q,     state_d;
  logic                            cmd_ready_q, cmd_ready_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                      rsp_resp_q,  rsp_resp_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q,      addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q,     wdata_d;
  logic                            awvalid_q,   awvalid_d;
  logic                            wvalid_q,    wvalid_d;
  logic                            bready_q,    bready_d;
  logic                            arvalid_q,   arvalid_d;
  logic                            rready_q,    rready_d;
  logic                            aw_still_pending;
  logic                            w_still_pending;

  // Next-state and next-output logic; each AXI valid/ready is a flop and
  // valid is never derived from the slave's ready
  always_comb begin
    state_d          = state_q;
    cmd_ready_d      = cmd_ready_q;
    rsp_valid_d      = 1'b0;
    rsp_rdata_d      = rsp_rdata_q;
    rsp_resp_d       = rsp_resp_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    awvalid_d        = awvalid_q;
    wvalid_d         = wvalid_q;
    bready_d         = bready_q;
    arvalid_d        = arvalid_q;
    rready_d         = rready_q;
    aw_still_pending = awvalid_q & ~m_axi_awready;
    w_still_pending  = wvalid_q  & ~m_axi_wready;

    case (state_q)
      ST_IDLE: begin
        // cmd_ready rises the first cycle after reset and stays up while idle
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_AR;
          end
        end
      end

      ST_WR_AW_W: begin
        // AW and W complete independently, in either order or together
        awvalid_d = aw_still_pending;
        wvalid_d  = w_still_pending;
        if (!aw_still_pending && !w_still_pending) begin
          bready_d = 1'b1;
          state_d  = ST_WR_B;
        end
      end

      ST_WR_B: begin
        if (m_axi_bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_RD_AR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_R;
        end
      end

      ST_RD_R: begin
        if (m_axi_rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

  // One latched address feeds both address channels; only one is ever valid
  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_cmd_master
//  Description : Self-checking bench for axi_lite_cmd_master with a
//                4-register AXI4-Lite slave model and a register-file
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_lite_cmd_master;
  import axi_lite_pkg::*;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid, m_axi_rready;

  always #5 aclk = ~aclk;

  axi_lite_cmd_master #(
    .C_M_AXI_DATA_WIDTH (32),
    .C_M_AXI_ADDR_WIDTH (32)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  // ---------------- slave model configuration ----------------
  int          aw_delay    = 0;     // cycles awvalid waits before awready
  bit          w_imm       = 1'b0;  // accept W without waiting for AW
  logic [1:0]  force_bresp = RESP_OKAY;
  logic [1:0]  force_rresp = RESP_OKAY;
  bit          force_rd    = 1'b0;
  logic [31:0] force_rdata = '0;

  // ---------------- 4-register slave model ----------------
  logic [31:0] s_mem [4];
  logic        aw_got, w_got, ar_got;
  logic [31:0] aw_addr_s, w_data_s, ar_addr_s;
  int          aw_cnt;
  logic        bvalid_s, rvalid_s;
  logic [1:0]  bresp_s, rresp_s;
  logic [31:0] rdata_s;

  assign m_axi_awready = m_axi_awvalid && !aw_got && (aw_cnt >= aw_delay);
  assign m_axi_wready  = m_axi_wvalid && !w_got && (w_imm || aw_got);
  assign m_axi_arready = m_axi_arvalid && !ar_got && !rvalid_s;
  assign m_axi_bvalid  = bvalid_s;
  assign m_axi_bresp   = bresp_s;
  assign m_axi_rvalid  = rvalid_s;
  assign m_axi_rdata   = rdata_s;
  assign m_axi_rresp   = rresp_s;

  wire         aw_hs = m_axi_awvalid && m_axi_awready;
  wire         w_hs  = m_axi_wvalid && m_axi_wready;
  wire         ar_hs = m_axi_arvalid && m_axi_arready;
  wire [31:0]  s_wa  = aw_got ? aw_addr_s : m_axi_awaddr;
  wire [31:0]  s_wd  = w_got ? w_data_s : m_axi_wdata;

  always @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < 4; i++) s_mem[i] <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_addr_s <= '0; w_data_s <= '0; ar_addr_s <= '0;
      aw_cnt <= 0;
      bvalid_s <= 1'b0; rvalid_s <= 1'b0;
      bresp_s <= '0; rresp_s <= '0; rdata_s <= '0;
    end else begin
      if (m_axi_awvalid && !m_axi_awready && !aw_got) aw_cnt <= aw_cnt + 1;
      if (aw_hs) begin
        aw_cnt <= 0; aw_got <= 1'b1; aw_addr_s <= m_axi_awaddr;
      end
      if (w_hs) begin
        w_got <= 1'b1; w_data_s <= m_axi_wdata;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        s_mem[s_wa[3:2]] <= s_wd;
        bvalid_s <= 1'b1;
        bresp_s  <= force_bresp;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
      if (bvalid_s && m_axi_bready) bvalid_s <= 1'b0;
      if (ar_hs) begin
        ar_got <= 1'b1; ar_addr_s <= m_axi_araddr;
      end
      if (ar_got && !rvalid_s) begin
        rvalid_s <= 1'b1;
        rdata_s  <= force_rd ? force_rdata : s_mem[ar_addr_s[3:2]];
        rresp_s  <= force_rresp;
        ar_got   <= 1'b0;
      end
      if (rvalid_s && m_axi_rready) rvalid_s <= 1'b0;
    end
  end

  // ---------------- protocol monitors ----------------
  int          cyc = 0;
  int          rsp_cnt = 0;
  int          viol = 0;
  logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
  logic        mon_aw = 1'b0, mon_w = 1'b0, bready_prev = 1'b0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0, b_rise_cyc = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (areset) begin
      aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
      mon_aw <= 1'b0; mon_w <= 1'b0; bready_prev <= 1'b0;
    end else begin
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
      // a valid that was not accepted must still be up now
      if ((aw_pend && !m_axi_awvalid) || (w_pend && !m_axi_wvalid) ||
          (ar_pend && !m_axi_arvalid)) viol <= viol + 1;
      // bready only once both write handshakes are done
      if (m_axi_bready && !(mon_aw && mon_w)) viol <= viol + 1;
      aw_pend <= m_axi_awvalid && !m_axi_awready;
      w_pend  <= m_axi_wvalid && !m_axi_wready;
      ar_pend <= m_axi_arvalid && !m_axi_arready;
      if (aw_hs) begin mon_aw <= 1'b1; aw_hs_cyc <= cyc; cap_awaddr <= m_axi_awaddr; end
      if (w_hs)  begin mon_w  <= 1'b1; w_hs_cyc  <= cyc; cap_wdata  <= m_axi_wdata;  end
      if (ar_hs) cap_araddr <= m_axi_araddr;
      if (m_axi_bvalid && m_axi_bready) begin mon_aw <= 1'b0; mon_w <= 1'b0; end
      if (m_axi_bready && !bready_prev) b_rise_cyc <= cyc;
      bready_prev <= m_axi_bready;
    end
  end

  // ---------------- reference model and checking ----------------
  int          total = 0;
  int          bad = 0;
  int          exp_rsp_cnt = 0;
  logic [31:0] exp_mem [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge
  task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input bit hold);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("cmd_accept_timeout", 64'(n < 50), 64'd1);
    @(posedge aclk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Returns at the negedge of the rsp_valid cycle; lat=4 means N+4
  task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rs, output int lat);
    lat = 1;
    @(negedge aclk);
    while (rsp_valid !== 1'b1 && lat < 60) begin
      @(negedge aclk);
      lat++;
    end
    check("rsp_timeout", 64'(lat < 60), 64'd1);
    rd = rsp_rdata;
    rs = rsp_resp;
  endtask

  task automatic do_txn(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit hold, input int exp_lat);
    logic [31:0] rd, exp_rd;
    logic [1:0]  rs, exp_rs;
    int          lat;
    send_cmd(wr, addr, data, hold);
    wait_rsp(rd, rs, lat);
    exp_rs = wr ? force_bresp : force_rresp;
    exp_rd = wr ? 32'h0 : (force_rd ? force_rdata : exp_mem[addr[3:2]]);
    if (wr) exp_mem[addr[3:2]] = data;
    exp_rsp_cnt++;
    check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
    check({tag, "_resp"}, 64'(rs), 64'(exp_rs));
    if (exp_lat > 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (wr) begin
      check({tag, "_awaddr"}, 64'(cap_awaddr), 64'(addr));
      check({tag, "_wdata"}, 64'(cap_wdata), 64'(data));
    end else begin
      check({tag, "_araddr"}, 64'(cap_araddr), 64'(addr));
    end
  endtask

  task automatic reset_cfg();
    aw_delay = 0; w_imm = 1'b0; force_bresp = RESP_OKAY; force_rresp = RESP_OKAY;
    force_rd = 1'b0; force_rdata = '0;
  endtask

  initial begin
    int n;
    bit wr;
    logic [31:0] a, d;
    for (int i = 0; i < 4; i++) exp_mem[i] = '0;

    // reset state
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_resp, rsp_rdata}), 64'd0);
    check("rst_handshakes", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                 m_axi_arvalid, m_axi_rready}), 64'd0);
    check("rst_addr_data", 64'({m_axi_awaddr, m_axi_wdata}), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // 1: basic write then read
    do_txn("t1_wr", 1'b1, 32'h04, 32'hA5A50001, 1'b0, 4);
    do_txn("t1_rd", 1'b0, 32'h04, 32'h0, 1'b0, 4);

    // 2: cmd_valid held across back-to-back commands
    for (int i = 0; i < 4; i++)
      do_txn("t2_wr", 1'b1, 32'(i * 4), 32'(8'h11 * (i + 1)), 1'b1, 4);
    for (int i = 0; i < 4; i++)
      do_txn("t2_rd", 1'b0, 32'(i * 4), 32'h0, 1'b1, 4);
    cmd_valid = 1'b0;
    @(negedge aclk);

    // 3: AW delayed, W accepted first
    aw_delay = 5; w_imm = 1'b1;
    do_txn("t3_wr", 1'b1, 32'h08, 32'h0BADF00D, 1'b0, -1);
    check("t3_w_before_aw", 64'(w_hs_cyc < aw_hs_cyc), 64'd1);
    check("t3_bready_after_aw", 64'(b_rise_cyc), 64'(aw_hs_cyc + 1));
    reset_cfg();

    // 4: error responses forwarded unchanged
    force_bresp = RESP_SLVERR;
    do_txn("t4_wr", 1'b1, 32'h0C, 32'h12345678, 1'b0, 4);
    force_rresp = RESP_DECERR; force_rd = 1'b1; force_rdata = 32'hDEADBEEF;
    do_txn("t4_rd", 1'b0, 32'h0C, 32'h0, 1'b0, 4);
    reset_cfg();

    // 5: reset while waiting for B
    send_cmd(1'b1, 32'h00, 32'h55555555, 1'b0);
    n = 0;
    while (m_axi_bready !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    check("t5_reached_wr_b", 64'(n < 20), 64'd1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    for (int i = 0; i < 4; i++) exp_mem[i] = '0;
    check("t5_handshakes_clear", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                      m_axi_arvalid, m_axi_rready, rsp_valid}), 64'd0);
    check("t5_cmd_ready_low", 64'(cmd_ready), 64'd0);
    @(negedge aclk);
    check("t5_cmd_ready_high", 64'(cmd_ready), 64'd1);
    do_txn("t5_rd", 1'b0, 32'h00, 32'h0, 1'b0, 4);

    // 6: unaligned/out-of-range address passed through; slave decodes [3:2]
    do_txn("t6_wr", 1'b1, 32'h00, 32'h77, 1'b0, 4);
    do_txn("t6_rd", 1'b0, 32'h10, 32'h0, 1'b0, 4);

    // randomized traffic with random slave timing and responses
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom_range(0, 1));
      a = $urandom();
      d = $urandom();
      aw_delay = int'($urandom_range(0, 3));
      w_imm = 1'($urandom_range(0, 1));
      force_bresp = 2'($urandom_range(0, 3));
      force_rresp = 2'($urandom_range(0, 3));
      do_txn("rnd", wr, a, d, 1'($urandom_range(0, 1)), -1);
    end
    cmd_valid = 1'b0;
    reset_cfg();
    repeat (3) @(negedge aclk);

    check("rsp_pulse_count", 64'(rsp_cnt), 64'(exp_rsp_cnt));
    check("protocol_violations", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
